// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 keyboard receiver and key encoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;
   localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

   localparam int KEY_STROBE  = 10;
   localparam int KEY_PRESSED = 9;
   localparam int KEY_EXT     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_e;

   // Bytes the keyboard sends in reply to host commands; they are not key events.
   function automatic logic isDeviceReply(input logic [7:0] code);
      case (code)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: line synchronizers, clock glitch filter, frame FSM and timeout.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 49152
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2Clk_i,
   input  logic       ps2Dat_i,
   output logic [7:0] rxByte_o,
   output logic       byteValid_o,
   output logic       frameErr_o
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW  = $clog2(TIMEOUT);
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);

   logic [1:0]     clkSync_q, datSync_q;
   logic [FCW-1:0] filtCnt_q;
   logic           filtClk_q;
   ps2_state_e     state_q, state_d;
   logic [2:0]     bitCnt_q, bitCnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           parity_q, parity_d;
   logic [TW-1:0]  toCnt_q, toCnt_d;
   logic [7:0]     rxByte_q;
   logic           byteValid_q, frameErr_q;
   logic           validSet, errSet;
   logic           fallEdge, datBit;

   // Filtered clock only flips once the synchronized line has disagreed with it FILTER_LEN times in a row.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clkSync_q <= 2'b11;
         datSync_q <= 2'b11;
         filtCnt_q <= '0;
         filtClk_q <= 1'b1;
      end else begin
         clkSync_q <= {clkSync_q[0], ps2Clk_i};
         datSync_q <= {datSync_q[0], ps2Dat_i};
         if (clkSync_q[1] == filtClk_q) begin
            filtCnt_q <= '0;
         end else if (filtCnt_q == FILT_LAST) begin
            filtClk_q <= clkSync_q[1];
            filtCnt_q <= '0;
         end else begin
            filtCnt_q <= filtCnt_q + 1'b1;
         end
      end
   end

   assign fallEdge = filtClk_q && !clkSync_q[1] && (filtCnt_q == FILT_LAST);
   assign datBit   = datSync_q[1];

   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      toCnt_d  = toCnt_q;
      validSet = 1'b0;
      errSet   = 1'b0;
      if (fallEdge) begin
         toCnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!datBit) begin
                  state_d  = ST_DATA;
                  bitCnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d  = {datBit, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = datBit;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               if ((^{shift_q, parity_q}) && datBit) validSet = 1'b1;
               else                                   errSet   = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // A stalled frame is abandoned; the counter holds at its limit rather than wrapping.
         if (toCnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            errSet  = 1'b1;
         end else begin
            toCnt_d = toCnt_q + 1'b1;
         end
      end else begin
         toCnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         bitCnt_q    <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         toCnt_q     <= '0;
         rxByte_q    <= 8'h00;
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         toCnt_q     <= toCnt_d;
         byteValid_q <= validSet;
         frameErr_q  <= errSet;
         if (validSet) rxByte_q <= shift_q;
      end
   end

   assign rxByte_o    = rxByte_q;
   assign byteValid_o = byteValid_q;
   assign frameErr_o  = frameErr_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// Folds E0/F0/E1 prefixes from received PS/2 bytes into one toggle-strobed ps2_key event per key transition.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 49152
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   logic [7:0]  rxByte;
   logic        rxValid, rxErr;
   logic [10:0] key_q, key_d;
   logic        ext_q, ext_d;
   logic        brk_q, brk_d;
   logic [2:0]  skip_q, skip_d;

   ps2_rx_frame #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) uRxFrame (
      .clk_i       (clk),
      .rst_i       (RESET),
      .ps2Clk_i    (ps2_clk_in),
      .ps2Dat_i    (ps2_dat_in),
      .rxByte_o    (rxByte),
      .byteValid_o (rxValid),
      .frameErr_o  (rxErr)
   );

   // A corrupted frame may have been part of a prefixed sequence, so pending prefixes are dropped.
   always_comb begin
      key_d  = key_q;
      ext_d  = ext_q;
      brk_d  = brk_q;
      skip_d = skip_q;
      if (rxErr) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rxValid) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else if (rxByte == PS2_PAUSE) begin
            skip_d = PS2_PAUSE_SKIP;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
         end else if (rxByte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (rxByte == PS2_BRK) begin
            brk_d = 1'b1;
         end else if (!ext_q && !brk_q && isDeviceReply(rxByte)) begin
            key_d = key_q;
         end else begin
            key_d[KEY_STROBE]  = ~key_q[KEY_STROBE];
            key_d[KEY_PRESSED] = ~brk_q;
            key_d[KEY_EXT]     = ext_q;
            key_d[7:0]         = rxByte;
            ext_d              = 1'b0;
            brk_d              = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         key_q  <= 11'h000;
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         skip_q <= 3'd0;
      end else begin
         key_q  <= key_d;
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         skip_q <= skip_d;
      end
   end

   assign ps2_key   = key_q;
   assign frame_err = rxErr;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: directed PS/2 frames in, key events and frame errors checked by a monitor.
module tb_ps2_key_encoder;

   localparam int HALF       = 20;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 49152;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        ps2_clk_in = 1'b1;
   logic        ps2_dat_in = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   typedef struct packed {
      logic        isErr;
      logic [10:0] key;
   } ev_t;

   ev_t         expQ[$];
   int          testsRun = 0;
   int          testsFailed = 0;
   logic [10:0] prevKey = 11'h000;

   ps2_key_encoder #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk        (clk),
      .RESET      (RESET),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expectKey(input logic [10:0] k);
      expQ.push_back(ev_t'({1'b0, k}));
   endtask

   task automatic expectErr();
      expQ.push_back(ev_t'({1'b1, 11'h000}));
   endtask

   task automatic handleEvent(input logic isErr, input logic [10:0] key);
      ev_t e;
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL unexpected event: got err=%b key=%h, expected none", isErr, key);
      end else begin
         e = expQ.pop_front();
         checkOutput(e.isErr ? "frame_err event" : "ps2_key event",
                     {isErr, isErr ? 11'h000 : key},
                     {e.isErr, e.isErr ? 11'h000 : e.key});
      end
   endtask

   // Drives nBits of an 11-bit frame (start, 8 data LSB first, odd parity, stop) on the PS/2 pins.
   task automatic applyStimulus(input logic [7:0] code, input logic badParity, input int nBits);
      logic [10:0] frame;
      frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         ps2_dat_in = frame[i];
         repeat (HALF) @(posedge clk);
         ps2_clk_in = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk_in = 1'b1;
      end
      ps2_dat_in = 1'b1;
      repeat (2 * HALF) @(posedge clk);
   endtask

   task automatic sendByte(input logic [7:0] code);
      applyStimulus(code, 1'b0, 11);
   endtask

   always @(negedge clk) begin
      if (RESET) begin
         prevKey = ps2_key;
      end else begin
         if (frame_err) handleEvent(1'b1, ps2_key);
         if (ps2_key !== prevKey) handleEvent(1'b0, ps2_key);
         prevKey = ps2_key;
      end
   end

   initial begin
      RESET = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset ps2_key", {1'b0, ps2_key}, 12'h000);
      checkOutput("reset frame_err", {11'h000, frame_err}, 12'h000);
      RESET = 1'b0;
      repeat (10) @(posedge clk);

      expectKey(11'h61C); sendByte(8'h1C);
      expectKey(11'h01C); sendByte(8'hF0); sendByte(8'h1C);

      expectKey(11'h775); sendByte(8'hE0); sendByte(8'h75);
      expectKey(11'h175); sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
      expectKey(11'h575); sendByte(8'hF0); sendByte(8'hE0); sendByte(8'h75);

      sendByte(8'hE0);
      expectErr(); applyStimulus(8'h29, 1'b1, 11);
      expectKey(11'h229); sendByte(8'h29);

      expectErr(); applyStimulus(8'h5A, 1'b0, 4);
      repeat (TIMEOUT + 200) @(posedge clk);
      expectKey(11'h616); sendByte(8'h16);

      sendByte(8'hE1); sendByte(8'h14); sendByte(8'h77); sendByte(8'hE1);
      sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
      sendByte(8'hAA);

      ps2_dat_in = 1'b0;
      repeat (4) @(posedge clk);
      ps2_clk_in = 1'b0;
      repeat (FILTER_LEN - 3) @(posedge clk);
      ps2_clk_in = 1'b1;
      repeat (4) @(posedge clk);
      ps2_dat_in = 1'b1;
      repeat (2 * HALF) @(posedge clk);
      expectKey(11'h21C); sendByte(8'h1C);
      expectKey(11'h61C); sendByte(8'h1C);

      sendByte(8'hE0);
      applyStimulus(8'h3C, 1'b0, 5);
      @(posedge clk);
      #1 RESET = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("mid-frame reset ps2_key", {1'b0, ps2_key}, 12'h000);
      checkOutput("mid-frame reset frame_err", {11'h000, frame_err}, 12'h000);
      RESET = 1'b0;
      repeat (10) @(posedge clk);
      expectKey(11'h61C); sendByte(8'h1C);

      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
      checkOutput("scoreboard drained", 12'(expQ.size()), 12'h000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
